// File: rtl/dmem_access_ctrl.sv
// MEM-stage data cache access controller: registers one access, holds it until the cache
// responds or times out, stalls the pipeline meanwhile and keeps saturating perf counters.
module dmem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_valid,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_byte_enable,
    input  logic             mem_resp,
    input  logic [31:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_enable,
    output logic             stall_mem,
    output logic [31:0]      rdata_out,
    output logic             rdata_valid,
    output logic             err_both,
    output logic             err_timeout,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
    localparam logic [WaitW-1:0] WaitOne  = {{(WaitW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic             mem_read_q, mem_write_q;
    logic [31:0]      mem_address_q, mem_wdata_q, rdata_out_q;
    logic [3:0]       mem_byte_enable_q;
    logic             rdata_valid_q, err_both_q, err_timeout_q;
    logic             is_load_q;
    logic [WaitW-1:0] wait_q;
    logic [CNT_W-1:0] load_cnt_q, store_cnt_q, stall_cnt_q;

    logic new_req, conflict;

    assign new_req   = pipe_valid & (req_read ^ req_write);
    assign conflict  = pipe_valid & req_read & req_write;
    // Stall starts combinationally in the issue cycle so EX/MEM holds the issuing instruction.
    assign stall_mem = (state_q == StBusy) | ((state_q == StIdle) & new_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= 32'h0;
            mem_wdata_q       <= 32'h0;
            mem_byte_enable_q <= 4'b0000;
            rdata_out_q       <= 32'h0;
            rdata_valid_q     <= 1'b0;
            err_both_q        <= 1'b0;
            err_timeout_q     <= 1'b0;
            is_load_q         <= 1'b0;
            wait_q            <= '0;
            load_cnt_q        <= '0;
            store_cnt_q       <= '0;
            stall_cnt_q       <= '0;
        end else begin
            rdata_valid_q <= 1'b0;
            if (stall_mem && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            unique case (state_q)
                StIdle: begin
                    if (new_req) begin
                        mem_read_q        <= req_read;
                        mem_write_q       <= req_write;
                        mem_address_q     <= req_addr;
                        mem_wdata_q       <= req_wdata;
                        mem_byte_enable_q <= req_byte_enable;
                        is_load_q         <= req_read;
                        wait_q            <= '0;
                        state_q           <= StBusy;
                    end else if (conflict) begin
                        err_both_q <= 1'b1;
                    end
                end
                StBusy: begin
                    wait_q <= wait_q + WaitOne;
                    if (mem_resp) begin
                        if (is_load_q) begin
                            rdata_out_q   <= mem_rdata;
                            rdata_valid_q <= 1'b1;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= StDone;
                    end else if (wait_q == WaitLast) begin
                        // Abandoned access: zeroed data is handed back for loads.
                        mem_read_q    <= 1'b0;
                        mem_write_q   <= 1'b0;
                        err_timeout_q <= 1'b1;
                        rdata_out_q   <= 32'h0;
                        rdata_valid_q <= is_load_q;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    if (is_load_q) begin
                        if (load_cnt_q != CntMax) load_cnt_q <= load_cnt_q + CntOne;
                    end else begin
                        if (store_cnt_q != CntMax) store_cnt_q <= store_cnt_q + CntOne;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_byte_enable_q;
    assign rdata_out       = rdata_out_q;
    assign rdata_valid     = rdata_valid_q;
    assign err_both        = err_both_q;
    assign err_timeout     = err_timeout_q;
    assign load_cnt        = load_cnt_q;
    assign store_cnt       = store_cnt_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized scoreboard bench for dmem_access_ctrl: a transaction-level model predicts each
// cache access and its completion; a monitor checks what the DUT presents.
module tb_dmem_access_ctrl;

    localparam int unsigned MW = 4;
    localparam int unsigned CW = 2;
    localparam int CntMax = (1 << CW) - 1;

    logic          clk, rst;
    logic          pipe_valid, req_read, req_write, mem_resp;
    logic [31:0]   req_addr, req_wdata, mem_rdata;
    logic [3:0]    req_byte_enable;
    logic          mem_read, mem_write, stall_mem, rdata_valid, err_both, err_timeout;
    logic [31:0]   mem_address, mem_wdata, rdata_out;
    logic [3:0]    mem_byte_enable;
    logic [CW-1:0] load_cnt, store_cnt, stall_cnt;

    dmem_access_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .req_read(req_read),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_enable(req_byte_enable), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .stall_mem(stall_mem),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .err_both(err_both),
        .err_timeout(err_timeout), .load_cnt(load_cnt), .store_cnt(store_cnt),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          len;
        logic        to;
        logic [31:0] rdata;
    } item_t;

    item_t q_exp[$];
    int    n_chk = 0, n_fail = 0;
    int    raw_load = 0, raw_store = 0, raw_stall = 0;
    logic  exp_eb = 1'b0, exp_eto = 1'b0, exp_stall_now = 1'b0;
    logic  mon_active = 1'b0;

    function automatic logic [31:0] sat(input int v);
        return (v > CntMax) ? 32'(CntMax) : 32'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        item_t       cur;
        int          hi;
        logic        post_rst;
        logic [31:0] last_rd, exp_rd;
        hi = 0;
        post_rst = 1'b0;
        last_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                post_rst = 1'b1;
                last_rd = 32'h0;
                continue;
            end
            if (post_rst) begin
                chk("rst_strobes", 32'({mem_read, mem_write}), 32'h0);
                chk("rst_addr", mem_address, 32'h0);
                chk("rst_wdata", mem_wdata, 32'h0);
                chk("rst_be", 32'(mem_byte_enable), 32'h0);
                chk("rst_rdata", rdata_out, 32'h0);
                chk("rst_rvalid", 32'(rdata_valid), 32'h0);
                post_rst = 1'b0;
            end
            chk("stall_mem", 32'(stall_mem), 32'(exp_stall_now));
            chk("err_both", 32'(err_both), 32'(exp_eb));
            chk("err_timeout", 32'(err_timeout), 32'(exp_eto));
            chk("load_cnt", 32'(load_cnt), sat(raw_load));
            chk("store_cnt", 32'(store_cnt), sat(raw_store));
            chk("stall_cnt", 32'(stall_cnt), sat(raw_stall));
            if ((mem_read | mem_write) && !mon_active) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_issue", 32'({mem_read, mem_write}), 32'h0);
                end else begin
                    cur = q_exp.pop_front();
                    mon_active = 1'b1;
                    hi = 1;
                    chk("issue_read", 32'(mem_read), 32'(cur.rd));
                    chk("issue_write", 32'(mem_write), 32'(!cur.rd));
                    chk("issue_addr", mem_address, cur.addr);
                    chk("issue_wdata", mem_wdata, cur.wdata);
                    chk("issue_be", 32'(mem_byte_enable), 32'(cur.be));
                end
            end else if ((mem_read | mem_write) && mon_active) begin
                hi++;
                chk("held_strobes", 32'({mem_read, mem_write}), 32'({cur.rd, !cur.rd}));
                chk("held_addr", mem_address, cur.addr);
                chk("held_wdata", mem_wdata, cur.wdata);
                chk("held_be", 32'(mem_byte_enable), 32'(cur.be));
            end else if (mon_active) begin
                mon_active = 1'b0;
                exp_rd = cur.to ? 32'h0 : (cur.rd ? cur.rdata : last_rd);
                chk("busy_len", 32'(hi), 32'(cur.len));
                chk("done_rvalid", 32'(rdata_valid), 32'(cur.rd));
                chk("done_rdata", rdata_out, exp_rd);
                last_rd = exp_rd;
            end else begin
                chk("rvalid_idle", 32'(rdata_valid), 32'h0);
            end
        end
    end

    // ---------------- driver + model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 1'b0;
        req_read = 1'($urandom);
        req_write = 1'($urandom);
        mem_resp = 1'($urandom);
        mem_rdata = $urandom;
        exp_stall_now = 1'b0;
    endtask

    // k: BUSY cycle (1-based) carrying mem_resp; out of 1..MW means no response (timeout).
    task automatic do_access(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, input int k, input logic hold,
                             input logic [31:0] rdv);
        item_t it;
        it.rd = rd;
        it.addr = addr;
        it.wdata = wd;
        it.be = be;
        it.to = !(k >= 1 && k <= int'(MW));
        it.len = it.to ? int'(MW) : k;
        it.rdata = rdv;
        q_exp.push_back(it);
        pipe_valid = 1'b1;
        req_read = rd;
        req_write = !rd;
        req_addr = addr;
        req_wdata = wd;
        req_byte_enable = be;
        mem_resp = 1'b0;
        exp_stall_now = 1'b1;
        tick();
        raw_stall++;
        for (int j = 1; j <= it.len; j++) begin
            req_addr = $urandom;
            req_wdata = $urandom;
            req_byte_enable = 4'($urandom);
            req_read = 1'($urandom);
            req_write = 1'($urandom);
            mem_resp = (j == k);
            mem_rdata = (j == k) ? rdv : $urandom;
            tick();
            raw_stall++;
        end
        if (it.to) exp_eto = 1'b1;
        exp_stall_now = 1'b0;
        mem_resp = 1'($urandom);
        mem_rdata = $urandom;
        if (hold) begin
            req_read = rd;
            req_write = !rd;
            req_addr = addr;
            req_wdata = wd;
            req_byte_enable = be;
        end else begin
            pipe_valid = 1'b0;
        end
        tick();
        if (rd) raw_load++;
        else raw_store++;
        idle();
    endtask

    task automatic do_conflict();
        pipe_valid = 1'b1;
        req_read = 1'b1;
        req_write = 1'b1;
        exp_stall_now = 1'b0;
        tick();
        exp_eb = 1'b1;
        idle();
    endtask

    task automatic do_noise(input logic valid_no_req);
        pipe_valid = valid_no_req;
        req_read = valid_no_req ? 1'b0 : 1'b1;
        req_write = valid_no_req ? 1'b0 : 1'($urandom);
        req_addr = $urandom;
        exp_stall_now = 1'b0;
        tick();
        idle();
    endtask

    task automatic model_reset();
        raw_load = 0;
        raw_store = 0;
        raw_stall = 0;
        exp_eb = 1'b0;
        exp_eto = 1'b0;
        q_exp.delete();
    endtask

    task automatic do_reset_mid();
        item_t it;
        it.rd = 1'b1;
        it.addr = $urandom;
        it.wdata = $urandom;
        it.be = 4'($urandom);
        it.len = int'(MW);
        it.to = 1'b1;
        it.rdata = 32'h0;
        q_exp.push_back(it);
        pipe_valid = 1'b1;
        req_read = 1'b1;
        req_write = 1'b0;
        req_addr = it.addr;
        req_wdata = it.wdata;
        req_byte_enable = it.be;
        mem_resp = 1'b0;
        exp_stall_now = 1'b1;
        tick();
        raw_stall++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    initial begin
        int op;
        rst = 1'b1;
        pipe_valid = 1'b0;
        req_read = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_byte_enable = 4'h0;
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) tick();
        rst = 1'b0;
        idle();
        tick();

        do_access(1'b1, 32'h100, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF);
        do_access(1'b0, 32'h204, 32'h12345678, 4'b0100, 1, 1'b0, 32'h0);
        do_access(1'b1, 32'h300, 32'h0, 4'hF, 1, 1'b1, 32'hCAFEF00D);
        tick();
        do_access(1'b1, 32'h304, 32'h0, 4'hF, 3, 1'b0, 32'h0BADF00D);
        do_conflict();
        do_noise(1'b0);
        do_noise(1'b1);
        do_access(1'b1, 32'h400, 32'h0, 4'hF, 0, 1'b0, 32'h55AA55AA);
        do_access(1'b1, 32'h404, 32'h0, 4'hF, int'(MW), 1'b0, 32'h13579BDF);
        do_access(1'b0, 32'h408, 32'hA5A5A5A5, 4'b0011, 0, 1'b0, 32'h0);
        do_reset_mid();
        tick();
        for (int i = 0; i < 4; i++) do_access(1'b1, 32'h500 + 32'(4 * i), 32'h0, 4'hF, 1,
                                               1'b0, $urandom);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 0) do_conflict();
            else if (op == 1) do_noise(1'($urandom));
            else if (op == 2) do_reset_mid();
            else if (op == 3) tick();
            else do_access(1'($urandom), $urandom, $urandom, 4'($urandom),
                           int'($urandom_range(0, MW + 1)), 1'($urandom), $urandom);
        end

        idle();
        repeat (3) tick();
        chk("queue_empty", 32'(q_exp.size()), 32'h0);
        chk("no_open_access", 32'(mon_active), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
